spi_word_slave: RTL and testbench
=================================

Name: spi_word_slave

Overview:
- Parametrised SPI slave (mode 0) for the FPGA fabric. Runs entirely in the system clock domain; sck, sdi and nss are oversampled through synchronisers.
- Full-duplex: receives WIDTH-bit words on sdi and presents each one with a one-cycle valid strobe. Shifts out a buffered transmit word on sdo.
- Sits between the external MCU SPI master and downstream consumers, such as the seven-segment display path or a command decoder.

Parameters:
- WIDTH, 8, bits per SPI word (2..32).
- MSB_FIRST, 1, 1 = MSB shifted first on both sdi and sdo; 0 = LSB first.
- SYNC_STAGES, 2, synchroniser flops on sck/sdi/nss (≥2).

Ports:
- clk  in  1  system clock; must be ≥ 4× sck frequency.
- rst  in  1  asynchronous reset, active-low.
- sck  in  1  SPI clock from master (CPOL=0).
- sdi  in  1  SPI data in (MOSI).
- sdo  out  1  SPI data out (MISO).
- nss  in  1  chip select, active-low.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  one-clk pulse: rx_data updated.
- tx_data  in  WIDTH  word to transmit.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  transmit buffer empty; handshake completes on tx_valid && tx_ready.
- busy  out  1  nss synchronised low (transfer in progress).
- rx_overrun  out  1  sticky overrun flag (see Optional Feature).

Behaviour:
- Reset (rst=0, async) values:
  - rx_data=0, rx_valid=0, sdo=0, tx_ready=1, busy=0, rx_overrun=0.
  - Shift registers, bit counter and tx buffer cleared.
  - Synchronisers reset to idle levels: sck=0, nss=1.
- Edge detect: all edges are taken from synchronised signals. Latency from a pin edge to internal action is SYNC_STAGES+1 clk.
- States:
  - IDLE: nss_s=1. sdo=0, bit_cnt=0. nss_s falling → LOAD.
  - LOAD (1 clk): tx_shift ← tx buffer if full, else all-zeros. Buffer is marked empty (tx_ready=1 next cycle). sdo presents the first bit. → SHIFT.
  - SHIFT:
    - sck_s rising: sample sdi_s into rx_shift; bit_cnt++.
    - sck_s falling: advance tx_shift so sdo shows the next bit.
    - When bit_cnt reaches WIDTH on a rising edge:
      - rx_data ← assembled word, rx_valid=1 for exactly one clk the cycle after.
      - bit_cnt=0; → LOAD at the following sck_s falling edge. Back-to-back words need no nss toggle.
    - nss_s rising in any state → IDLE. A partial word is discarded (no rx_valid, rx_data unchanged) and bit_cnt cleared.
- Bit order: MSB_FIRST=1 shifts left, sdi enters at bit 0 and sdo=tx_shift[WIDTH-1]. MSB_FIRST=0 mirrors this.
- tx buffer:
  - Written on tx_valid && tx_ready; tx_ready then drops the next clk.
  - If the write and a LOAD occur in the same clk, LOAD consumes the old buffer state (empty → zeros), and the new word stays buffered for the next word.
- sdo is registered; it is driven 0 whenever nss_s=1 (no tri-state in this block).
- busy = ~nss_s.
- Glitch rule: an sck_s edge while nss_s=1 is ignored.

Optional Feature:
- Macro SPI_OVERRUN_EN.
- Defined:
  - A word completing while the previous rx word is unacknowledged sets rx_overrun (sticky until rst).
  - Acknowledgement requires an extra input rx_ack, pulsed by the consumer. When enabled, rx_valid is level-held until rx_ack instead of pulsing.
  - The new word still overwrites rx_data.
- Undefined: rx_ack port absent, rx_valid is a 1-clk pulse, rx_overrun tied 0.

Test Plan:
- Reset: hold rst=0 with random pins → all outputs at reset values. Release rst → tx_ready=1, sdo=0.
- Single byte, WIDTH=8, MSB_FIRST=1: preload tx 0xA5, master sends 0x3C at sck=clk/8 → rx_data=0x3C with one rx_valid pulse; master captures 0xA5; tx_ready=1 after LOAD.
- Back-to-back: nss held low, master sends 0x12,0x34; tx preloaded 0x56 then 0x78 → two rx_valid pulses (0x12, 0x34); master reads 0x56, 0x78; no nss toggle required.
- Empty tx buffer: no tx write, master sends 0xFF → master reads 0x00; rx_data=0xFF.
- Abort: nss rises after 5 of 8 bits of 0xC3 → no rx_valid, rx_data keeps its prior value. Next full transfer of 0x81 → rx_data=0x81.
- Parametrised: WIDTH=12, MSB_FIRST=0, master sends 0xABC LSB-first → rx_data=0xABC.
- With SPI_OVERRUN_EN: send two words without rx_ack → rx_overrun=1 and rx_data = second word.

Source files
------------

// File: rtl/spi_word_slave.sv
// SPI mode-0 word slave oversampled in the system clock domain, full-duplex, buffered transmit.
// Optional feature macro SPI_OVERRUN_EN: rx_valid held until i_rx_ack, sticky o_rx_overrun.
module spi_word_slave #(
   parameter int unsigned WIDTH       = 8,
   parameter bit          MSB_FIRST   = 1'b1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_sck,
   input  logic             i_sdi,
   output logic             o_sdo,
   input  logic             i_nss,
   output logic [WIDTH-1:0] o_rx_data,
   output logic             o_rx_valid,
`ifdef SPI_OVERRUN_EN
   input  logic             i_rx_ack,
`endif
   input  logic [WIDTH-1:0] i_tx_data,
   input  logic             i_tx_valid,
   output logic             o_tx_ready,
   output logic             o_busy,
   output logic             o_rx_overrun
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_sdi_sync;
   logic [SYNC_STAGES-1:0] r_nss_sync;
   logic                   r_sck_d;
   logic                   r_nss_d;

   logic w_sck_s, w_sdi_s, w_nss_s;
   logic w_sck_rise, w_sck_fall, w_nss_rise, w_nss_fall;

   state_e           r_state;
   logic [CntW-1:0]  r_bit_cnt;
   logic [WIDTH-1:0] r_tx_shift;
   logic [WIDTH-1:0] r_rx_shift;
   logic [WIDTH-1:0] r_rx_data;
   logic             r_rx_valid;
   logic [WIDTH-1:0] r_tx_buf;
   logic             r_tx_full;
   logic             r_sdo;

   logic [WIDTH-1:0] w_load_word;
   logic [WIDTH-1:0] w_tx_shifted;
   logic [WIDTH-1:0] w_rx_next;
   logic             w_sdo_load;
   logic             w_sdo_shift;
   logic             w_tx_write;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sck_sync <= '0;
         r_sdi_sync <= '0;
         r_nss_sync <= '1;
         r_sck_d    <= 1'b0;
         r_nss_d    <= 1'b1;
      end else begin
         r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
         r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], i_sdi};
         r_nss_sync <= {r_nss_sync[SYNC_STAGES-2:0], i_nss};
         r_sck_d    <= w_sck_s;
         r_nss_d    <= w_nss_s;
      end
   end

   assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
   assign w_sdi_s    = r_sdi_sync[SYNC_STAGES-1];
   assign w_nss_s    = r_nss_sync[SYNC_STAGES-1];
   assign w_sck_rise = w_sck_s & ~r_sck_d;
   assign w_sck_fall = ~w_sck_s & r_sck_d;
   assign w_nss_rise = w_nss_s & ~r_nss_d;
   assign w_nss_fall = ~w_nss_s & r_nss_d;

   assign w_load_word = r_tx_full ? r_tx_buf : '0;
   assign w_tx_write  = i_tx_valid & ~r_tx_full;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_tx_shifted = {r_tx_shift[WIDTH-2:0], 1'b0};
         assign w_rx_next    = {r_rx_shift[WIDTH-2:0], w_sdi_s};
         assign w_sdo_load   = w_load_word[WIDTH-1];
         assign w_sdo_shift  = w_tx_shifted[WIDTH-1];
      end else begin : g_lsb_first
         assign w_tx_shifted = {1'b0, r_tx_shift[WIDTH-1:1]};
         assign w_rx_next    = {w_sdi_s, r_rx_shift[WIDTH-1:1]};
         assign w_sdo_load   = w_load_word[0];
         assign w_sdo_shift  = w_tx_shifted[0];
      end
   endgenerate

`ifdef SPI_OVERRUN_EN
   logic r_overrun;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= StIdle;
         r_bit_cnt  <= '0;
         r_tx_shift <= '0;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_tx_buf   <= '0;
         r_tx_full  <= 1'b0;
         r_sdo      <= 1'b0;
`ifdef SPI_OVERRUN_EN
         r_overrun  <= 1'b0;
`endif
      end else begin
`ifdef SPI_OVERRUN_EN
         if (i_rx_ack) r_rx_valid <= 1'b0;
`else
         r_rx_valid <= 1'b0;
`endif
         if (w_nss_rise) begin
            // Deselect aborts any partial word; rx_data keeps the last complete word.
            r_state   <= StIdle;
            r_bit_cnt <= '0;
            r_sdo     <= 1'b0;
         end else begin
            unique case (r_state)
               StIdle: begin
                  r_sdo     <= 1'b0;
                  r_bit_cnt <= '0;
                  if (w_nss_fall) r_state <= StLoad;
               end
               StLoad: begin
                  r_tx_shift <= w_load_word;
                  r_sdo      <= w_sdo_load;
                  r_tx_full  <= 1'b0;
                  r_state    <= StShift;
               end
               StShift: begin
                  if (w_sck_rise) begin
                     r_rx_shift <= w_rx_next;
                     if (r_bit_cnt == CntW'(WIDTH - 1)) begin
                        r_rx_data  <= w_rx_next;
                        r_rx_valid <= 1'b1;
`ifdef SPI_OVERRUN_EN
                        if (r_rx_valid && !i_rx_ack) r_overrun <= 1'b1;
`endif
                        r_bit_cnt  <= '0;
                        r_state    <= StDone;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + CntW'(1);
                     end
                  end else if (w_sck_fall) begin
                     r_tx_shift <= w_tx_shifted;
                     r_sdo      <= w_sdo_shift;
                  end
               end
               StDone: begin
                  // Next word starts on the trailing falling edge of the last bit.
                  if (w_sck_fall) r_state <= StLoad;
               end
            endcase
         end
         // A write can only land in an empty buffer, so it overrides the LOAD clear above.
         if (w_tx_write) begin
            r_tx_buf  <= i_tx_data;
            r_tx_full <= 1'b1;
         end
      end
   end

   assign o_sdo      = r_sdo;
   assign o_rx_data  = r_rx_data;
   assign o_rx_valid = r_rx_valid;
   assign o_tx_ready = ~r_tx_full;
   assign o_busy     = ~w_nss_s;
`ifdef SPI_OVERRUN_EN
   assign o_rx_overrun = r_overrun;
`else
   assign o_rx_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_slave.sv
// Bench for spi_word_slave: 8-bit MSB-first and 12-bit LSB-first instances behind one SPI master.
// Table-driven single transfers, hand-written corner sequences, random transfers vs a word-level model.
module tb_spi_word_slave;

   logic        clk;
   logic        rst_n;
   logic        sck;
   logic        sdi;
   logic        nss;
   logic        sel;
   logic [31:0] tx_data;
   logic        tx_valid;

   logic        sck_a, nss_a, txv_a, sck_b, nss_b, txv_b;
   logic        sdo_a, sdo_b, rxv_a, rxv_b, txr_a, txr_b, busy_a, busy_b, ovr_a, ovr_b;
   logic [7:0]  rxd_a;
   logic [11:0] rxd_b;
   logic        sdo_m, rxv_m, txr_m, busy_m, ovr_m;
   logic [31:0] rxd_m;

   // sel=0 routes the master to the 8-bit instance, sel=1 to the 12-bit one
   assign sck_a  = ~sel & sck;
   assign nss_a  = sel | nss;
   assign txv_a  = ~sel & tx_valid;
   assign sck_b  = sel & sck;
   assign nss_b  = ~sel | nss;
   assign txv_b  = sel & tx_valid;
   assign sdo_m  = sel ? sdo_b : sdo_a;
   assign rxv_m  = sel ? rxv_b : rxv_a;
   assign txr_m  = sel ? txr_b : txr_a;
   assign busy_m = sel ? busy_b : busy_a;
   assign ovr_m  = sel ? ovr_b : ovr_a;
   assign rxd_m  = sel ? {20'h0, rxd_b} : {24'h0, rxd_a};

`ifdef SPI_OVERRUN_EN
   logic auto_ack;
   logic ack_a, ack_b;
   assign ack_a = auto_ack & rxv_a;
   assign ack_b = rxv_b;
`endif

   spi_word_slave #(.WIDTH(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_dut8 (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_sck        (sck_a),
      .i_sdi        (sdi),
      .o_sdo        (sdo_a),
      .i_nss        (nss_a),
      .o_rx_data    (rxd_a),
      .o_rx_valid   (rxv_a),
`ifdef SPI_OVERRUN_EN
      .i_rx_ack     (ack_a),
`endif
      .i_tx_data    (tx_data[7:0]),
      .i_tx_valid   (txv_a),
      .o_tx_ready   (txr_a),
      .o_busy       (busy_a),
      .o_rx_overrun (ovr_a)
   );

   spi_word_slave #(.WIDTH(12), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u_dut12 (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_sck        (sck_b),
      .i_sdi        (sdi),
      .o_sdo        (sdo_b),
      .i_nss        (nss_b),
      .o_rx_data    (rxd_b),
      .o_rx_valid   (rxv_b),
`ifdef SPI_OVERRUN_EN
      .i_rx_ack     (ack_b),
`endif
      .i_tx_data    (tx_data[11:0]),
      .i_tx_valid   (txv_b),
      .o_tx_ready   (txr_b),
      .o_busy       (busy_b),
      .o_rx_overrun (ovr_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // rx_valid monitor: counts strobes, high cycles and records the word of each strobe
   int          pulse_cnt = 0;
   int          hi_cycles = 0;
   logic        rxv_prev  = 1'b0;
   logic [31:0] rx_q[$];

   always @(negedge clk) begin
      if (rst_n && rxv_m) begin
         hi_cycles++;
         if (!rxv_prev) begin
            pulse_cnt++;
            rx_q.push_back(rxd_m);
         end
      end
      rxv_prev = rxv_m;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tx_write(input logic [31:0] d);
      @(negedge clk);
      check("tx_ready_before_write", {31'h0, txr_m}, 32'h1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("tx_ready_after_write", {31'h0, txr_m}, 32'h0);
   endtask

   task automatic nss_low();
      @(negedge clk);
      nss = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic nss_high();
      @(negedge clk);
      nss = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Mode-0 master at sck = clk/8: data changes with sck low, slave output sampled before rise.
   task automatic master_word(input int n, input bit msb, input logic [31:0] mosi,
                              input int nbits, output logic [31:0] miso);
      miso = '0;
      for (int i = 0; i < nbits; i++) begin
         int idx;
         idx = msb ? (n - 1 - i) : i;
         sdi = mosi[idx];
         repeat (4) @(negedge clk);
         miso[idx] = sdo_m;
         sck = 1'b1;
         repeat (4) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic run_xfer(input bit tx_en, input logic [31:0] txw, input logic [31:0] mosi,
                           input int nbits, output logic [31:0] miso, output int pulses);
      int p0;
      if (tx_en) tx_write(txw);
      p0 = pulse_cnt;
      nss_low();
      if (tx_en) check("tx_ready_after_load", {31'h0, txr_m}, 32'h1);
      master_word(8, 1'b1, mosi, nbits, miso);
      nss_high();
      pulses = pulse_cnt - p0;
   endtask

   typedef struct {
      bit         tx_en;
      logic [7:0] tx;
      logic [7:0] mosi;
      int         nbits;
      logic [7:0] exp_rx;
      int         exp_pulses;
      logic [7:0] exp_miso;
   } vec_t;

   vec_t        vecs[5];
   logic [31:0] miso, miso2;
   int          pulses;
   logic [31:0] model_rx;
   bit          model_pending;
   logic [31:0] model_word;

   initial begin
      vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8, 8'h3C, 1, 8'hA5};
      vecs[1] = '{1'b0, 8'h00, 8'hFF, 8, 8'hFF, 1, 8'h00};
      vecs[2] = '{1'b1, 8'h5A, 8'hC3, 5, 8'hFF, 0, 8'h00};
      vecs[3] = '{1'b0, 8'h00, 8'h81, 8, 8'h81, 1, 8'h00};
      vecs[4] = '{1'b1, 8'hFF, 8'h00, 8, 8'h00, 1, 8'hFF};

      sel      = 1'b0;
      rst_n    = 1'b0;
      sck      = 1'b0;
      sdi      = 1'b0;
      nss      = 1'b1;
      tx_data  = '0;
      tx_valid = 1'b0;
`ifdef SPI_OVERRUN_EN
      auto_ack = 1'b1;
`endif

      // Reset with random pin activity
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         sck      = 1'($urandom_range(0, 1));
         sdi      = 1'($urandom_range(0, 1));
         nss      = 1'($urandom_range(0, 1));
         tx_data  = $urandom;
         tx_valid = 1'($urandom_range(0, 1));
      end
      check("rst_rx_data", rxd_m, 32'h0);
      check("rst_rx_valid", {31'h0, rxv_m}, 32'h0);
      check("rst_sdo", {31'h0, sdo_m}, 32'h0);
      check("rst_tx_ready", {31'h0, txr_m}, 32'h1);
      check("rst_busy", {31'h0, busy_m}, 32'h0);
      check("rst_overrun", {31'h0, ovr_m}, 32'h0);
      @(negedge clk);
      sck      = 1'b0;
      nss      = 1'b1;
      tx_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_tx_ready", {31'h0, txr_m}, 32'h1);
      check("post_rst_sdo", {31'h0, sdo_m}, 32'h0);

      // Table of single-word transfers on the 8-bit instance
      for (int i = 0; i < 5; i++) begin
         run_xfer(vecs[i].tx_en, {24'h0, vecs[i].tx}, {24'h0, vecs[i].mosi}, vecs[i].nbits,
                  miso, pulses);
         check($sformatf("vec%0d_rx_data", i), rxd_m, {24'h0, vecs[i].exp_rx});
         check($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
         if (vecs[i].nbits == 8)
            check($sformatf("vec%0d_miso", i), miso, {24'h0, vecs[i].exp_miso});
      end

      // sck toggling while deselected must be ignored
      for (int i = 0; i < 3; i++) begin
         repeat (4) @(negedge clk);
         sck = 1'b1;
         repeat (4) @(negedge clk);
         sck = 1'b0;
      end
      repeat (4) @(negedge clk);
      check("glitch_busy", {31'h0, busy_m}, 32'h0);
      check("glitch_rx_data", rxd_m, 32'h0);
      run_xfer(1'b0, 32'h0, 32'h96, 8, miso, pulses);
      check("glitch_next_rx", rxd_m, 32'h96);
      check("glitch_next_pulses", pulses, 1);

      // Back-to-back words without an nss toggle; second tx word written mid-transfer
      tx_write(32'h56);
      rx_q.delete();
      nss_low();
      check("b2b_busy", {31'h0, busy_m}, 32'h1);
      tx_write(32'h78);
      master_word(8, 1'b1, 32'h12, 8, miso);
      master_word(8, 1'b1, 32'h34, 8, miso2);
      nss_high();
      check("b2b_miso0", miso, 32'h56);
      check("b2b_miso1", miso2, 32'h78);
      check("b2b_rx_count", rx_q.size(), 2);
      check("b2b_rx0", (rx_q.size() > 0) ? rx_q[0] : 32'hDEAD, 32'h12);
      check("b2b_rx1", (rx_q.size() > 1) ? rx_q[1] : 32'hDEAD, 32'h34);
      check("b2b_tx_ready", {31'h0, txr_m}, 32'h1);

      // Random transfers against a word-level model
      model_rx      = 32'h34;
      model_pending = 1'b0;
      model_word    = '0;
      for (int k = 0; k < 24; k++) begin
         bit          tx_en, abort;
         logic [31:0] txw, mosi, exp_miso;
         int          nbits;
         tx_en = 1'($urandom_range(0, 1));
         txw   = 32'($urandom_range(0, 255));
         mosi  = 32'($urandom_range(0, 255));
         abort = ($urandom_range(0, 3) == 0);
         nbits = abort ? int'($urandom_range(1, 7)) : 8;
         if (tx_en) begin
            model_pending = 1'b1;
            model_word    = txw;
         end
         exp_miso      = model_pending ? model_word : 32'h0;
         model_pending = 1'b0;
         run_xfer(tx_en, txw, mosi, nbits, miso, pulses);
         if (!abort) model_rx = mosi;
         check($sformatf("rnd%0d_rx_data", k), rxd_m, model_rx);
         check($sformatf("rnd%0d_pulses", k), pulses, abort ? 0 : 1);
         if (!abort) check($sformatf("rnd%0d_miso", k), miso, exp_miso);
      end
      check("rx_valid_width", hi_cycles, pulse_cnt);

      // 12-bit LSB-first instance
      @(negedge clk);
      sel = 1'b1;
      repeat (2) @(negedge clk);
      tx_write(32'h5C3);
      begin
         int p0;
         p0 = pulse_cnt;
         nss_low();
         master_word(12, 1'b0, 32'hABC, 12, miso);
         nss_high();
         pulses = pulse_cnt - p0;
      end
      check("w12_rx_data", rxd_m, 32'hABC);
      check("w12_pulses", pulses, 1);
      check("w12_miso", miso, 32'h5C3);
      @(negedge clk);
      sel = 1'b0;
      repeat (2) @(negedge clk);

`ifdef SPI_OVERRUN_EN
      auto_ack = 1'b0;
      run_xfer(1'b0, 32'h0, 32'h11, 8, miso, pulses);
      check("ovr_first_no_flag", {31'h0, ovr_m}, 32'h0);
      run_xfer(1'b0, 32'h0, 32'h22, 8, miso, pulses);
      check("ovr_flag", {31'h0, ovr_m}, 32'h1);
      check("ovr_rx_data", rxd_m, 32'h22);
      check("ovr_rx_valid_held", {31'h0, rxv_m}, 32'h1);
`else
      check("overrun_tied_low", {31'h0, ovr_m}, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
